// File: rtl/mem_port_arbiter.sv
// Three-way arbiter and access sequencer for the single-port unified word memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority ld > d > if.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [31:0]       d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [31:0]       ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_e;
    typedef enum logic [1:0] {PORT_IF, PORT_D, PORT_LD} port_e;

    state_e              state_q, state_d;
    port_e               sel_q, sel_d;
    logic                wr_q, wr_d;
    logic                mis_q, mis_d;
    logic [2:0]          gnt_q, gnt_d;
    logic [2:0]          rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                any_req;
    port_e               win;
    logic [31:0]         win_addr;
    logic                win_we;
    logic [DATA_W-1:0]   win_wdata;
    logic                unused_addr_hi;

`ifdef MEM_ARB_RR_EN
    port_e               rr_ptr_q, rr_ptr_d;
`endif

    // Winner selection; round-robin makes the last-granted port lowest priority.
    always_comb begin
        any_req = if_req_i | d_req_i | ld_req_i;
        win     = PORT_IF;
`ifdef MEM_ARB_RR_EN
        case (rr_ptr_q)
            PORT_IF: begin
                if (d_req_i)       win = PORT_D;
                else if (ld_req_i) win = PORT_LD;
                else               win = PORT_IF;
            end
            PORT_D: begin
                if (ld_req_i)      win = PORT_LD;
                else if (if_req_i) win = PORT_IF;
                else               win = PORT_D;
            end
            default: begin
                if (if_req_i)      win = PORT_IF;
                else if (d_req_i)  win = PORT_D;
                else               win = PORT_LD;
            end
        endcase
`else
        if (ld_req_i)      win = PORT_LD;
        else if (d_req_i)  win = PORT_D;
        else               win = PORT_IF;
`endif
    end

    // The fetch port is read-only, so it never changes the latched write data.
    always_comb begin
        win_addr  = if_addr_i;
        win_we    = 1'b0;
        win_wdata = mem_wdata_q;
        case (win)
            PORT_D: begin
                win_addr  = d_addr_i;
                win_we    = d_we_i;
                win_wdata = d_wdata_i;
            end
            PORT_LD: begin
                win_addr  = ld_addr_i;
                win_we    = ld_we_i;
                win_wdata = ld_wdata_i;
            end
            default: ;
        endcase
    end

    assign unused_addr_hi = ^win_addr[31:ADDR_W+2];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wr_d        = wr_q;
        mis_d       = mis_q;
        gnt_d       = 3'b000;
        rvalid_d    = 3'b000;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d[win]  = 1'b1;
                    sel_d       = win;
                    wr_d        = win_we;
                    mis_d       = |win_addr[1:0];
                    mem_en_d    = 1'b1;
                    mem_we_d    = win_we;
                    mem_addr_d  = win_addr[ADDR_W+1:2];
                    mem_wdata_d = win_wdata;
`ifdef MEM_ARB_RR_EN
                    rr_ptr_d    = win;
`endif
                    state_d     = ACCESS;
                end
            end
            ACCESS: state_d = WAIT;
            WAIT: begin
                if (!wr_q) rdata_d = mem_rdata_i;
                rvalid_d[sel_q] = 1'b1;
                err_d           = mis_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            sel_q       <= PORT_IF;
            wr_q        <= 1'b0;
            mis_q       <= 1'b0;
            gnt_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q    <= PORT_IF;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            mis_q       <= mis_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign if_gnt_o    = gnt_q[PORT_IF];
    assign d_gnt_o     = gnt_q[PORT_D];
    assign ld_gnt_o    = gnt_q[PORT_LD];
    assign if_rvalid_o = rvalid_q[PORT_IF];
    assign d_rvalid_o  = rvalid_q[PORT_D];
    assign ld_rvalid_o = rvalid_q[PORT_LD];
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
